// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, word-length and parity encodings
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // LCR word length select
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Parity mode as {sticky_parity, eps}, shared with the receiver checker
  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Number of data bits carried for a given word length select (5..8)
  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  // Mask keeping only the bits that belong to the selected word length
  function automatic logic [7:0] data_mask(input logic [1:0] wls);
    return 8'hFF >> (2'd3 - wls);
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// rtl/uart_parity_gen.sv - parity bit over word-length-masked data
module uart_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [1:0] wls_i,
  input  logic       eps_i,
  input  logic       sticky_parity_i,
  output logic       parity_o
);

  logic [7:0] masked;

  // Bits above the word length never reach the line, so they never count
  always_comb begin
    masked   = data_i & data_mask(wls_i);
    parity_o = 1'b0;
    case ({sticky_parity_i, eps_i})
      PAR_ODD:   parity_o = ~^masked;
      PAR_EVEN:  parity_o = ^masked;
      PAR_MARK:  parity_o = 1'b1;
      PAR_SPACE: parity_o = 1'b0;
      default:   parity_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_top.sv
// rtl/uart_tx_top.sv - UART transmitter; UART_TX_ONE_HALF_STOP_EN enables 1.5 stop bits for 5-bit words
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       stb,
  input  logic [1:0] wls,
  input  logic       set_break,
  input  logic       fifo_empty,
  input  logic [7:0] din,
  output logic       pop,
  output logic       tx,
  output logic       sreg_empty
);

  // One extra bit over a single bit time so a two-bit stop fits in one count
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE) + 1;
  localparam logic [TICK_W-1:0] BIT_LAST      = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TWO_STOP_LAST = TICK_W'(2 * OVERSAMPLE - 1);
`ifdef UART_TX_ONE_HALF_STOP_EN
  localparam logic [TICK_W-1:0] HALF_STOP_LAST = TICK_W'((OVERSAMPLE * 3) / 2 - 1);
`endif

  tx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [1:0]        wls_q, wls_d;
  logic              pen_q, pen_d;
  logic              stb_q, stb_d;
  logic              tx_q, tx_d;
  logic              sreg_empty_q, sreg_empty_d;

  logic              load;
  logic              par_bit;
  logic [TICK_W-1:0] tick_inc;
  logic [TICK_W-1:0] stop_last;
  logic [3:0]        last_bit;

  uart_parity_gen u_parity_gen (
    .data_i          (din),
    .wls_i           (wls),
    .eps_i           (eps),
    .sticky_parity_i (sticky_parity),
    .parity_o        (par_bit)
  );

  assign tick_inc = (tick_q == '1) ? tick_q : tick_q + 1'b1;
  assign last_bit = data_bits(wls_q) - 4'd1;

  // Stop length chosen from the frame snapshot, never from live LCR bits
  always_comb begin
    stop_last = BIT_LAST;
`ifdef UART_TX_ONE_HALF_STOP_EN
    if (stb_q && (wls_q == WLS_5)) begin
      stop_last = HALF_STOP_LAST;
    end else if (stb_q) begin
      stop_last = TWO_STOP_LAST;
    end
`else
    if (stb_q) begin
      stop_last = TWO_STOP_LAST;
    end
`endif
  end

  // Frame sequencer: advances only on baud ticks; load covers idle start and back-to-back
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    wls_d        = wls_q;
    pen_d        = pen_q;
    stb_d        = stb_q;
    sreg_empty_d = sreg_empty_q;
    load         = 1'b0;

    if (baud_pulse) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) load = 1'b1;
        end
        START: begin
          if (tick_q == BIT_LAST) begin
            state_d = DATA;
            tick_d  = '0;
          end else begin
            tick_d = tick_inc;
          end
        end
        DATA: begin
          if (tick_q == BIT_LAST) begin
            tick_d = '0;
            if ({1'b0, bit_q} == last_bit) begin
              bit_d   = '0;
              state_d = pen_q ? PARITY : STOP;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = shift_q >> 1;
            end
          end else begin
            tick_d = tick_inc;
          end
        end
        PARITY: begin
          if (tick_q == BIT_LAST) begin
            state_d = STOP;
            tick_d  = '0;
          end else begin
            tick_d = tick_inc;
          end
        end
        STOP: begin
          if (tick_q == stop_last) begin
            tick_d = '0;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d      = IDLE;
              sreg_empty_d = 1'b1;
            end
          end else begin
            tick_d = tick_inc;
          end
        end
        default: begin
          state_d      = IDLE;
          tick_d       = '0;
          sreg_empty_d = 1'b1;
        end
      endcase
    end

    if (load) begin
      state_d      = START;
      tick_d       = '0;
      bit_d        = '0;
      shift_d      = din;
      par_d        = par_bit;
      wls_d        = wls;
      pen_d        = pen;
      stb_d        = stb;
      sreg_empty_d = 1'b0;
    end
  end

  // Line level follows the state being entered, so tx changes on the same edge
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    if (set_break) tx_d = 1'b0;
  end

  // Pop is a same-cycle read strobe; reset suppresses it so no character is consumed
  assign pop        = load & ~rst;
  assign tx         = tx_q;
  assign sreg_empty = sreg_empty_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      wls_q        <= WLS_8;
      pen_q        <= 1'b0;
      stb_q        <= 1'b0;
      tx_q         <= 1'b1;
      sreg_empty_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wls_q        <= wls_d;
      pen_q        <= pen_d;
      stb_q        <= stb_d;
      tx_q         <= tx_d;
      sreg_empty_q <= sreg_empty_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// tb/tb_uart_tx_top.sv - directed self-checking bench for uart_tx_top
module tb_uart_tx_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse;
  logic       pen;
  logic       eps;
  logic       sticky_parity;
  logic       stb;
  logic [1:0] wls;
  logic       set_break;
  logic       fifo_empty;
  logic [7:0] din;
  logic       pop;
  logic       tx;
  logic       sreg_empty;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int pc;

  uart_tx_top #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .stb           (stb),
    .wls           (wls),
    .set_break     (set_break),
    .fifo_empty    (fifo_empty),
    .din           (din),
    .pop           (pop),
    .tx            (tx),
    .sreg_empty    (sreg_empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pop === 1'b1) pop_cnt <= pop_cnt + 1;
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic p, input logic e,
                         input logic s, input logic st);
    wls = w; pen = p; eps = e; sticky_parity = s; stb = st;
  endtask

  // Present one character, check the pop, then scramble live config to prove the snapshot
  task automatic start_frame(input logic [7:0] d, input string tag);
    din        = d;
    fifo_empty = 1'b0;
    #1;
    chk(32'(pop), 32'd1, {tag, "_pop"});
    tick();
    fifo_empty    = 1'b1;
    din           = ~d;
    wls           = ~wls;
    pen           = ~pen;
    eps           = ~eps;
    sticky_parity = ~sticky_parity;
    stb           = ~stb;
    chk(32'(sreg_empty), 32'd0, {tag, "_busy"});
  endtask

  // exp[i] is the i-th bit on the line, start bit first; each held 16 ticks
  task automatic check_bits(input logic [11:0] exp, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int bad = 0;
      for (int j = 0; j < 16; j++) begin
        if (tx !== exp[i]) bad++;
        tick();
      end
      chk(32'(bad), 32'd0, $sformatf("%s_bit%0d", tag, i));
    end
  endtask

  task automatic check_stop(input int n, input string tag);
    int bad = 0;
    for (int j = 0; j < n; j++) begin
      if (tx !== 1'b1 || sreg_empty !== 1'b0 || pop !== 1'b0) bad++;
      tick();
    end
    chk(32'(bad), 32'd0, {tag, "_stop"});
    chk(32'(sreg_empty), 32'd1, {tag, "_temt"});
    chk(32'(tx), 32'd1, {tag, "_idle"});
  endtask

  initial begin
    rst = 1'b1; baud_pulse = 1'b1; set_break = 1'b0;
    fifo_empty = 1'b1; din = 8'h00;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk(32'(tx), 32'd1, "rst_tx");
    chk(32'(pop), 32'd0, "rst_pop");
    chk(32'(sreg_empty), 32'd1, "rst_temt");
    rst = 1'b0;

    // No baud tick: a waiting character is not taken
    baud_pulse = 1'b0; fifo_empty = 1'b0;
    #1;
    chk(32'(pop), 32'd0, "nobaud_pop");
    repeat (3) tick();
    chk(32'(sreg_empty), 32'd1, "nobaud_temt");
    chk(32'(pop_cnt), 32'd0, "nobaud_popcnt");
    fifo_empty = 1'b1; baud_pulse = 1'b1;
    tick();

    // 8N1 0x55
    pc = pop_cnt;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    start_frame(8'h55, "f55");
    check_bits(12'h0AA, 9, "f55");
    check_stop(16, "f55");
    chk(32'(pop_cnt - pc), 32'd1, "f55_popcnt");

    // 0xA3 even parity -> 0, odd parity -> 1
    set_cfg(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    start_frame(8'hA3, "a3e");
    check_bits(12'h146, 10, "a3e");
    check_stop(16, "a3e");
    set_cfg(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    start_frame(8'hA3, "a3o");
    check_bits(12'h346, 10, "a3o");
    check_stop(16, "a3o");

    // 6-bit word: parity over masked 0xAA (101010, three ones) even -> 1
    set_cfg(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    start_frame(8'hAA, "aa6");
    check_bits(12'h0D4, 8, "aa6");
    check_stop(16, "aa6");

    // 5-bit word, one stop: 112 ticks in all
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    start_frame(8'hFF, "ff5");
    check_bits(12'h03E, 6, "ff5");
    check_stop(16, "ff5");

    // 5-bit word, stb=1
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    start_frame(8'hFF, "ff5s");
    check_bits(12'h03E, 6, "ff5s");
`ifdef UART_TX_ONE_HALF_STOP_EN
    check_stop(24, "ff5s");
`else
    check_stop(32, "ff5s");
`endif

    // 8-bit word, stb=1 is always two stop bits
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    start_frame(8'h0F, "f0f");
    check_bits(12'h01E, 9, "f0f");
    check_stop(32, "f0f");

    // Stick parity on 0x07 (three ones): mark -> 1, space -> 0
    set_cfg(2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    start_frame(8'h07, "mark");
    check_bits(12'h20E, 10, "mark");
    check_stop(16, "mark");
    set_cfg(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    start_frame(8'h07, "space");
    check_bits(12'h00E, 10, "space");
    check_stop(16, "space");

    // Back-to-back 0x01 then 0x02 with no idle gap
    pc = pop_cnt;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    start_frame(8'h01, "b2b1");
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    din = 8'h02; fifo_empty = 1'b0;
    check_bits(12'h002, 9, "b2b1");
    repeat (15) begin
      if (tx !== 1'b1 || sreg_empty !== 1'b0 || pop !== 1'b0) begin
        chk(32'(tx), 32'd1, "b2b1_stop");
      end
      tick();
    end
    chk(32'(pop), 32'd1, "b2b_pop2");
    chk(32'(sreg_empty), 32'd0, "b2b_temt_gap");
    tick();
    fifo_empty = 1'b1;
    chk(32'(tx), 32'd0, "b2b2_start");
    chk(32'(sreg_empty), 32'd0, "b2b2_busy");
    check_bits(12'h004, 9, "b2b2");
    check_stop(16, "b2b2");
    chk(32'(pop_cnt - pc), 32'd2, "b2b_popcnt");

    // Break mid-DATA, release, then reset mid-frame
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    start_frame(8'hFF, "brk");
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    chk(32'(tx), 32'd1, "brk_pre");
    set_break = 1'b1;
    tick();
    chk(32'(tx), 32'd0, "brk_on");
    repeat (5) tick();
    chk(32'(tx), 32'd0, "brk_hold");
    set_break = 1'b0;
    tick();
    chk(32'(tx), 32'd1, "brk_off");
    pc = pop_cnt;
    fifo_empty = 1'b0;
    rst = 1'b1;
    tick();
    chk(32'(tx), 32'd1, "mrst_tx");
    chk(32'(sreg_empty), 32'd1, "mrst_temt");
    chk(32'(pop), 32'd0, "mrst_pop");
    fifo_empty = 1'b1;
    rst = 1'b0;
    repeat (40) tick();
    chk(32'(pop_cnt), 32'(pc), "mrst_nopop");
    chk(32'(tx), 32'd1, "mrst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
